// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter
//   Lets NUM_CH req/ack consumers share one req/ack producer. Toward the
//   producer it behaves as a single consumer: request, wait for the one-cycle
//   ack, capture the data. The captured word is then handed, with a one-cycle
//   ack, to the round-robin winner among the downstream requesters.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-low reset
//   o_up_req   request to the shared producer
//   i_up_ack   producer ack pulse; i_up_din valid in the same cycle
//   i_up_din   producer data
//   i_dn_req   per-channel request (bit i = channel i)
//   o_dn_ack   per-channel ack pulse, one-hot or zero
//   o_dn_dout  shared data register, valid while any o_dn_ack bit is high
//   o_grant    one-hot owner of the current transfer, zero when idle
//   o_count    completed transfers, wraps at 2^32
//   o_err      sticky: producer ack seen outside the WAIT state
module handshake_rr_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_up_req,
  input  logic                  i_up_ack,
  input  logic [DATA_WIDTH-1:0] i_up_din,
  input  logic [NUM_CH-1:0]     i_dn_req,
  output logic [NUM_CH-1:0]     o_dn_ack,
  output logic [DATA_WIDTH-1:0] o_dn_dout,
  output logic [NUM_CH-1:0]     o_grant,
  output logic [31:0]           o_count,
  output logic                  o_err
);

  localparam int PW = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  state_t                r_state, w_state_nxt;
  logic [PW-1:0]         r_ptr, w_ptr_nxt;
  logic [PW-1:0]         r_gidx, w_gidx_nxt;
  logic                  r_up_req, w_up_req_nxt;
  logic [NUM_CH-1:0]     r_dn_ack, w_dn_ack_nxt;
  logic [DATA_WIDTH-1:0] r_dn_dout, w_dn_dout_nxt;
  logic [NUM_CH-1:0]     r_grant, w_grant_nxt;
  logic [31:0]           r_count, w_count_nxt;
  logic                  r_err, w_err_nxt;
  logic [PW-1:0]         w_win;

  // First requesting channel at or after ptr, wrapping. Scanning from the
  // farthest offset down lets the nearest hit overwrite earlier ones.
  function automatic logic [PW-1:0] pick(input logic [NUM_CH-1:0] req,
                                         input logic [PW-1:0]     ptr);
    logic [PW-1:0] k;
    pick = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      k = PW'((int'(ptr) + i) % NUM_CH);
      if (req[k]) pick = k;
    end
  endfunction

  // Arbitration happens only in IDLE, so the "last served" mask that applies
  // during HOLD needs no logic: HOLD never samples requests.
  assign w_win = pick(i_dn_req, r_ptr);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gidx_nxt    = r_gidx;
    w_up_req_nxt  = r_up_req;
    w_dn_ack_nxt  = r_dn_ack;
    w_dn_dout_nxt = r_dn_dout;
    w_grant_nxt   = r_grant;
    w_count_nxt   = r_count;
    w_err_nxt     = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_up_ack) w_err_nxt = 1'b1;
        if (|i_dn_req) begin
          w_grant_nxt  = NUM_CH'(1) << w_win;
          w_gidx_nxt   = w_win;
          w_up_req_nxt = 1'b1;
          w_state_nxt  = S_WAIT;
        end else begin
          w_grant_nxt  = '0;
        end
      end
      S_WAIT: begin
        // A withdrawn request does not cancel: the grant is committed.
        w_up_req_nxt = 1'b1;
        if (i_up_ack) begin
          w_dn_dout_nxt = i_up_din;
          w_up_req_nxt  = 1'b0;
          w_dn_ack_nxt  = r_grant;
          w_state_nxt   = S_ACK;
        end
      end
      S_ACK: begin
        if (i_up_ack) w_err_nxt = 1'b1;
        w_dn_ack_nxt = '0;
        w_count_nxt  = r_count + 32'd1;
        w_ptr_nxt    = (r_gidx == PW'(NUM_CH - 1)) ? '0 : r_gidx + 1'b1;
        w_state_nxt  = S_HOLD;
      end
      S_HOLD: begin
        // Dead cycle so the served consumer's registered req can fall.
        if (i_up_ack) w_err_nxt = 1'b1;
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_up_req  <= 1'b0;
      r_dn_ack  <= '0;
      r_dn_dout <= '0;
      r_grant   <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gidx    <= w_gidx_nxt;
      r_up_req  <= w_up_req_nxt;
      r_dn_ack  <= w_dn_ack_nxt;
      r_dn_dout <= w_dn_dout_nxt;
      r_grant   <= w_grant_nxt;
      r_count   <= w_count_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign o_up_req  = r_up_req;
  assign o_dn_ack  = r_dn_ack;
  assign o_dn_dout = r_dn_dout;
  assign o_grant   = r_grant;
  assign o_count   = r_count;
  assign o_err     = r_err;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: a driver pushes expected (channel, data)
// pairs from a round-robin reference model, a producer model answers
// up_req with queued data, and a monitor checks every downstream ack.
module tb_handshake_rr_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;

  logic           clk, rst;
  logic           up_req, up_ack;
  logic [DW-1:0]  up_din;
  logic [NCH-1:0] dn_req, dn_ack, grant;
  logic [DW-1:0]  dn_dout;
  logic [31:0]    count;
  logic           err;

  handshake_rr_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst), .o_up_req(up_req), .i_up_ack(up_ack),
    .i_up_din(up_din), .i_dn_req(dn_req), .o_dn_ack(dn_ack),
    .o_dn_dout(dn_dout), .o_grant(grant), .o_count(count), .o_err(err));

  typedef struct { int ch; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] prod_q[$];
  int          prod_delay = 1;
  int          stray_cnt  = 0;
  int          n_checks   = 0;
  int          n_errors   = 0;
  int          cyc        = 0;
  int          m_ptr      = 0;
  logic [31:0] m_count    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: first requester at or after the pointer, pointer moves past it.
  function automatic int model_pick(input logic [NCH-1:0] mask);
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (m_ptr + i) % NCH;
      if (mask[c]) begin
        m_ptr = (c + 1) % NCH;
        return c;
      end
    end
    return -1;
  endfunction

  // Producer: acks a pending request after prod_delay cycles (>=1, i.e. a
  // registered producer), or emits a stray ack when asked.
  initial begin
    int stray_done;
    bit abort;
    stray_done = 0;
    up_ack = 1'b0;
    up_din = '0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_done) begin
        stray_done++;
        up_din = 32'hDEAD_BEEF;
        up_ack = 1'b1;
        @(negedge clk);
        up_ack = 1'b0;
      end else if (rst && up_req && prod_q.size() > 0) begin
        abort = 1'b0;
        for (int d = 0; d < prod_delay; d++) begin
          @(negedge clk);
          if (!rst) begin abort = 1'b1; break; end
          chk("up_req_held", up_req, 1);
        end
        if (!abort) begin
          up_din = prod_q.pop_front();
          up_ack = 1'b1;
          @(negedge clk);
          up_ack = 1'b0;
          chk("up_req_drop", up_req, 0);
        end
      end
    end
  end

  // Monitor: every ack must match the head of the scoreboard.
  initial begin
    logic [NCH-1:0] prev_ack;
    int last_ack;
    exp_t e;
    prev_ack = '0;
    last_ack = -100;
    forever begin
      @(negedge clk);
      if (rst && dn_ack != '0) begin
        if (prev_ack != '0) chk("ack_one_cycle", prev_ack, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", dn_ack, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dn_ack", dn_ack, 32'(1) << e.ch);
          chk("dn_dout", dn_dout, e.data);
          chk("grant", grant, 32'(1) << e.ch);
          chk("spacing_ge5", 32'(cyc - last_ack >= 5), 1);
        end
        last_ack = cyc;
      end
      prev_ack = rst ? dn_ack : '0;
    end
  end

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() > 0 && t < budget) begin
      @(negedge clk); #1; t++;
    end
    dn_req = '0;
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      prod_q.delete();
    end
    repeat (3) @(negedge clk);
    #1;
    chk("count", count, m_count);
  endtask

  task automatic run_phase(input logic [NCH-1:0] mask, input int n, input int dly,
                           input bit fixed, input logic [31:0] base);
    exp_t e;
    prod_delay = dly;
    for (int k = 0; k < n; k++) begin
      e.ch   = model_pick(mask);
      e.data = fixed ? base + 32'(k) : $urandom;
      exp_q.push_back(e);
      prod_q.push_back(e.data);
      m_count++;
    end
    dn_req = mask;
    wait_drain(n * (dly + 10) + 20);
  endtask

  initial begin
    exp_t e;
    int t;
    rst = 1'b1;
    dn_req = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_up_req", up_req, 0);
    chk("rst_dn_ack", dn_ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_dout", dn_dout, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Full contention from ptr 0: 0,1,2,3,0,1,2,3.
    run_phase(4'b1111, 8, 1, 1'b0, 0);
    chk("count_8", count, 8);
    // Single channel 2 with data 10,11,12.
    run_phase(4'b0100, 3, 1, 1'b1, 32'd10);
    chk("count_11", count, 11);
    // ptr now 3: 0011 -> 0,1,0.
    run_phase(4'b0011, 3, 2, 1'b0, 0);

    // Slow producer, all requests withdrawn mid-WAIT.
    prod_delay = 20;
    e.ch = model_pick(4'b1111);
    e.data = $urandom;
    exp_q.push_back(e);
    prod_q.push_back(e.data);
    m_count++;
    dn_req = 4'b1111;
    t = 0;
    while (!up_req && t < 10) begin @(negedge clk); t++; end
    chk("withdraw_up_req", up_req, 1);
    repeat (5) @(negedge clk);
    dn_req = '0;
    wait_drain(60);

    // Random phases.
    for (int p = 0; p < 12; p++)
      run_phase(NCH'($urandom_range(1, 15)), $urandom_range(1, 5),
                $urandom_range(1, 4), 1'b0, 0);

    // Stray ack in IDLE.
    chk("err_before_stray", err, 0);
    stray_cnt++;
    repeat (3) @(negedge clk);
    #1;
    chk("err_set", err, 1);
    chk("stray_count", count, m_count);

    // Count wrap from a preloaded all-ones value.
    @(negedge clk);
    dut.r_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    run_phase(4'b1000, 1, 1, 1'b0, 0);
    chk("count_wrap", count, 0);
    chk("err_sticky", err, 1);

    // Asynchronous reset in the middle of a long WAIT.
    prod_delay = 50;
    prod_q.push_back(32'h1234_5678);
    dn_req = 4'b0010;
    t = 0;
    while (!up_req && t < 10) begin @(negedge clk); t++; end
    chk("mid_wait_up_req", up_req, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    dn_req = '0;
    #1;
    chk("arst_up_req", up_req, 0);
    chk("arst_dn_ack", dn_ack, 0);
    chk("arst_grant", grant, 0);
    chk("arst_dout", dn_dout, 0);
    chk("arst_count", count, 0);
    chk("arst_err", err, 0);
    prod_q.delete();
    exp_q.delete();
    m_ptr = 0;
    m_count = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", up_req, 0);
    end
    // Pointer restarted at 0: 1010 -> channel 1 first.
    run_phase(4'b1010, 2, 1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=%0d", n_checks, 0);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/handshake_rr_arbiter.md
# handshake_rr_arbiter

Round-robin arbiter that lets `num_ch` req/ack consumers share one req/ack producer port. Typical uses are a single `in` source feeding several operator graphs, or one `arf` output drained by several consumers. Toward the shared upstream it acts as one consumer: it raises a request, waits for the single-cycle ack pulse, and captures the data. It then forwards that data and a one-cycle ack to exactly one granted downstream requester, and rotates priority after every completed transfer.

## Interface
- `num_ch`, 4, number of downstream requesters (2..16)
- `data_width`, 32, data bus width

- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `up_req`  out  1  request to the shared producer
- `up_ack`  in  1  producer ack pulse; `up_din` is valid in the same cycle
- `up_din`  in  `data_width`  producer data
- `dn_req`  in  `num_ch`  per-channel request; bit i belongs to channel i
- `dn_ack`  out  `num_ch`  per-channel ack pulse, one-hot or zero
- `dn_dout`  out  `data_width`  data register shared by all channels; valid while any `dn_ack` bit is high
- `grant`  out  `num_ch`  one-hot owner of the current transfer; zero when idle
- `count`  out  32  completed transfers; wraps 2^32-1 → 0
- `err`  out  1  sticky; set when `up_ack` is high outside WAIT

## Operation
- FSM states: IDLE, WAIT, ACK, HOLD. State, `ptr` (clog2 `num_ch` bits) and every output are registered.
- **IDLE**
  - If any eligible `dn_req` bit is high: `grant` ← winner, `up_req` ← 1, go to WAIT.
  - Otherwise stay in IDLE with `grant` = 0.
- **Winner selection:** the first high bit scanning `ptr`, `ptr`+1, …, wrapping modulo `num_ch`.
- **Eligibility:** every channel is eligible, except the channel served last, which is masked during HOLD only.
- **WAIT**
  - `up_req` is held high.
  - On `up_ack` = 1: `dn_dout` ← `up_din`, `up_req` ← 0, `dn_ack` ← `grant`, go to ACK.
  - A granted `dn_req` that drops during WAIT does not cancel the transfer. The transfer completes and the ack is still pulsed.
- **ACK**
  - `dn_ack` ← 0.
  - `count` ← `count`+1.
  - `ptr` ← (index of `grant` + 1) mod `num_ch`.
  - Go to HOLD.
- **HOLD**
  - `grant` ← 0, go to IDLE.
  - Purpose: one dead cycle so the served consumer's registered req can fall before it is sampled again.
- `dn_dout` holds its last value outside the ACK cycle.
- `err` is set by `up_ack` = 1 in IDLE, ACK or HOLD. Such a stray ack is otherwise ignored: no data capture, no ack, no count. `err` clears only on reset.

## Timing
- **Reset (`rst` = 0, immediate and asynchronous):**
  - `up_req` = 0, `dn_ack` = 0, `grant` = 0, `dn_dout` = 0, `count` = 0, `err` = 0.
  - `ptr` = 0, state = IDLE.
- **Release:** the first edge with `rst` = 1 may already arbitrate.
- **Reset mid-transfer:** the transfer is abandoned, no ack is issued, `count` is unchanged from its reset value of 0.
- **Request to upstream:** `dn_req` sampled at edge E0 → `up_req` and `grant` high after E0.
- **Upstream ack to downstream:** `up_ack` sampled at edge Ew → `dn_ack[g]` high for exactly one cycle after Ew, with `up_req` low from Ew.
- **Minimum cycle spacing per transfer with a zero-wait producer:** IDLE 1, WAIT ≥2, ACK 1, HOLD 1. That is 5 cycles per transfer.
- **Fairness:** with all channels requesting continuously, grants rotate 0,1,…,`num_ch`-1,0. No channel waits more than `num_ch`-1 transfers.
- **Simultaneous events:**
  - New requests arriving during WAIT, ACK or HOLD are sampled only in IDLE.
  - `up_ack` arriving in the same edge as a `dn_req` change is handled by the rule for the current state alone.
- `up_req` never rises and falls in the same transfer without an intervening `up_ack` (protocol: the producer acks only on `req & ~ack`).

## Test plan
- **Reset:** drive `rst` = 0 mid-WAIT, asynchronously between edges → all outputs 0 before the next edge. After release with `dn_req` = 0, `up_req` stays 0.
- **Single channel:** `num_ch` = 4, only `dn_req[2]` high, producer returns 10, 11, 12 → `dn_ack` = 4'b0100 pulses three times, `dn_dout` = 10, 11, 12, `count` = 3, transfers spaced ≥5 cycles.
- **Full contention:** all four `dn_req` held high for 8 transfers → grant order 0,1,2,3,0,1,2,3, each channel receives 2 values, `count` = 8.
- **Wrap and skip:** `ptr` = 3 with `dn_req` = 4'b0011 → channel 0 wins, then channel 1, then channel 0 again.
- **Slow producer, withdrawn request:**
  - `up_ack` delayed 20 cycles → `up_req` stays high for the whole wait.
  - `dn_req[g]` dropped mid-WAIT → ack still pulsed to g, `count` increments.
- **Stray ack and wrap:** `up_ack` pulsed in IDLE → `err` = 1 and stays 1, `count` unchanged. Preloaded `count` = 32'hFFFFFFFF plus one transfer → `count` = 0.
